// File: rtl/program_sequencer_pkg.sv
// Shared decode constants for the program sequencer.
// Holds the opcode classes, reg_en bit positions, data_bus source codes and FSM states.
package program_sequencer_pkg;

    typedef enum logic {
        FETCH,
        OPERAND
    } state_t;

    // Opcode class prefixes; LOAD is identified by bit 7 being clear
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [2:0] OP_ALU  = 3'b110;
    localparam logic [2:0] OP_JUMP = 3'b111;

    localparam logic [3:0] EN_X0    = 4'd0;
    localparam logic [3:0] EN_X1    = 4'd1;
    localparam logic [3:0] EN_Y0    = 4'd2;
    localparam logic [3:0] EN_Y1    = 4'd3;
    localparam logic [3:0] EN_R     = 4'd4;
    localparam logic [3:0] EN_M     = 4'd5;
    localparam logic [3:0] EN_I     = 4'd6;
    localparam logic [3:0] EN_DM    = 4'd7;
    localparam logic [3:0] EN_O_REG = 4'd8;

    localparam logic [3:0] SRC_PM_DATA = 4'd8;
    localparam logic [3:0] SRC_I_PINS  = 4'd9;
    localparam logic [3:0] SRC_IDLE    = 4'd15;

    localparam logic [2:0] DDD_I  = 3'd6;
    localparam logic [2:0] DDD_DM = 3'd7;

    // Destination field code 4 targets o_reg rather than r (r is written only by ALU ops)
    function automatic logic [3:0] dest_index(input logic [2:0] ddd);
        return (ddd == 3'd4) ? EN_O_REG : {1'b0, ddd};
    endfunction

endpackage

// File: rtl/program_counter.sv
// 8-bit program counter: asynchronous clear, load of a jump target, otherwise increment.
module program_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] target,
    output logic [7:0] pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else begin
            pc <= pc + 8'd1;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Instruction fetch/decode sequencer: decodes the ROM byte at the PC into register
// load enables and data_bus source selects; jumps take a second cycle for the target.
module program_sequencer
    import program_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pm_data,
    input  logic       r_eq_0,
    output logic [7:0] pm_address,
    output logic [8:0] reg_en,
    output logic [3:0] source_sel,
    output logic [3:0] ir_nibble,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel
);

    state_t     state, state_next;
    logic       jnz_latched, jnz_next;
    logic       pc_load;
    logic [2:0] load_dest, move_dest, move_src;

    assign load_dest = pm_data[6:4];
    assign move_dest = pm_data[5:3];
    assign move_src  = pm_data[2:0];

    program_counter u_program_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pc_load),
        .target  (pm_data),
        .pc      (pm_address)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            jnz_latched <= 1'b0;
        end else begin
            state       <= state_next;
            jnz_latched <= jnz_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        jnz_next   = jnz_latched;
        pc_load    = 1'b0;
        reg_en     = '0;
        source_sel = SRC_IDLE;
        ir_nibble  = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;

        if (state == OPERAND) begin
            pc_load = ~jnz_latched | ~r_eq_0;
        end else if (!pm_data[7]) begin
            reg_en[dest_index(load_dest)] = 1'b1;
            source_sel = SRC_PM_DATA;
            ir_nibble  = pm_data[3:0];
            if (load_dest == DDD_DM) begin
                reg_en[EN_I] = 1'b1;
                i_sel        = 1'b1;
            end
        end else if (pm_data[7:6] == OP_MOVE) begin
            reg_en[dest_index(move_dest)] = 1'b1;
            source_sel = (move_dest == move_src) ? SRC_I_PINS : {1'b0, move_src};
            // Any dm access post-increments i, except when i itself is the destination
            if ((move_dest == DDD_DM || move_src == DDD_DM) && move_dest != DDD_I) begin
                reg_en[EN_I] = 1'b1;
                i_sel        = 1'b1;
            end
        end else if (pm_data[7:5] == OP_ALU) begin
            reg_en[EN_R] = 1'b1;
            x_sel        = pm_data[4];
            y_sel        = pm_data[3];
            ir_nibble    = {1'b0, pm_data[2:0]};
        end else begin
            state_next = OPERAND;
            jnz_next   = pm_data[4];
        end

        if (!reset_n) begin
            reg_en     = '0;
            source_sel = SRC_IDLE;
            ir_nibble  = '0;
            i_sel      = 1'b0;
            x_sel      = 1'b0;
            y_sel      = 1'b0;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized and directed bench for program_sequencer against an instruction-level model.
module tb_program_sequencer;

    logic       clk;
    logic       reset_n;
    logic [7:0] pm_data;
    logic       r_eq_0;
    logic [7:0] pm_address;
    logic [8:0] reg_en;
    logic [3:0] source_sel;
    logic [3:0] ir_nibble;
    logic       i_sel, x_sel, y_sel;

    logic [7:0] rom [256];
    logic [7:0] trace [$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          r_mode   = 2;
    int          exp_pc   = 0;
    bit          in_operand  = 0;
    bit          jnz_pending = 0;

    program_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .pm_address (pm_address),
        .reg_en     (reg_en),
        .source_sel (source_sel),
        .ir_nibble  (ir_nibble),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel)
    );

    assign pm_data = rom[pm_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dest_pos(input int d);
        return (d == 4) ? 8 : d;
    endfunction

    // Expected outputs for one cycle, straight from the instruction-set rules
    function automatic void model_outputs(input bit operand, input int b,
                                          output int en, output int src, output int ir,
                                          output int ei, output int ex, output int ey);
        int d, s;
        en = 0; src = 15; ir = 0; ei = 0; ex = 0; ey = 0;
        if (operand) return;
        if (b < 128) begin
            d   = (b / 16) % 8;
            en  = 1 << dest_pos(d);
            src = 8;
            ir  = b % 16;
            if (d == 7) begin
                en = en | 64;
                ei = 1;
            end
        end else if (b < 192) begin
            d   = (b / 8) % 8;
            s   = b % 8;
            en  = 1 << dest_pos(d);
            src = (d == s) ? 9 : s;
            if ((d == 7 || s == 7) && d != 6) begin
                en = en | 64;
                ei = 1;
            end
        end else if (b < 224) begin
            en = 16;
            ex = (b / 16) % 2;
            ey = (b / 8) % 2;
            ir = b % 8;
        end
    endfunction

    // Called at a falling edge; checks this cycle and advances the model to the next one
    task automatic step();
        int b, en, src, ir, ei, ex, ey;
        case (r_mode)
            0:       r_eq_0 = 1'b0;
            1:       r_eq_0 = 1'b1;
            default: r_eq_0 = 1'($urandom_range(0, 1));
        endcase
        #1;
        b = int'(rom[exp_pc]);
        model_outputs(in_operand, b, en, src, ir, ei, ex, ey);
        trace.push_back(pm_address);
        check("pc",     32'(pm_address), 32'(exp_pc));
        check("reg_en", 32'(reg_en),     32'(en));
        check("src",    32'(source_sel), 32'(src));
        check("ir",     32'(ir_nibble),  32'(ir));
        check("i_sel",  32'(i_sel),      32'(ei));
        check("x_sel",  32'(x_sel),      32'(ex));
        check("y_sel",  32'(y_sel),      32'(ey));
        if (in_operand) begin
            exp_pc     = (!jnz_pending || !r_eq_0) ? b : (exp_pc + 1) % 256;
            in_operand = 0;
        end else begin
            if (b >= 224) begin
                jnz_pending = (b / 16) % 2 == 1;
                in_operand  = 1;
            end
            exp_pc = (exp_pc + 1) % 256;
        end
        @(negedge clk);
    endtask

    // Asserts reset between clock edges, checks the immediate effect, releases at a falling edge
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_pc",  32'(pm_address), 32'h0);
        check("rst_en",  32'(reg_en),     32'h0);
        check("rst_src", 32'(source_sel), 32'hF);
        check("rst_ir",  32'(ir_nibble),  32'h0);
        check("rst_sel", 32'({i_sel, x_sel, y_sel}), 32'h0);
        exp_pc      = 0;
        in_operand  = 0;
        jnz_pending = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_trace(input string tag, input logic [7:0] want [$]);
        check({tag, "_len"}, 32'(trace.size()), 32'(want.size()));
        for (int k = 0; k < want.size() && k < trace.size(); k++)
            check(tag, 32'(trace[k]), 32'(want[k]));
    endtask

    initial begin
        reset_n = 1'b0;
        r_eq_0  = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(0, 255));
        rom[0]     = 8'h05;  // LOAD x0,5
        rom[1]     = 8'hA7;  // MOVE o_reg <- dm
        rom[2]     = 8'h9B;  // MOVE y1 <- y1 (i_pins)
        rom[3]     = 8'hD2;  // ALU x1,y0,add
        rom[4]     = 8'hF0;  // JNZ
        rom[5]     = 8'h20;
        rom[8'h20] = 8'hE0;  // JMP
        rom[8'h21] = 8'hFF;
        rom[8'hFF] = 8'h03;  // LOAD x0,3
        @(negedge clk);

        // JNZ taken, then JMP to the top address and wrap
        r_mode = 0;
        do_reset();
        trace.delete();
        repeat (10) step();
        check_trace("jnz_taken", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                   8'h20, 8'h21, 8'hFF, 8'h00});

        // JNZ not taken still costs two cycles
        r_mode = 1;
        do_reset();
        trace.delete();
        repeat (7) step();
        check_trace("jnz_fall", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});

        // Reset while waiting for a jump operand abandons the jump
        do_reset();
        repeat (5) step();
        check("mid_operand", 32'(in_operand), 32'h1);
        do_reset();
        trace.delete();
        repeat (3) step();
        check_trace("after_abort", '{8'h00, 8'h01, 8'h02});

        // Random programs with random zero flag and occasional resets
        r_mode = 2;
        for (int round = 0; round < 4; round++) begin
            for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(0, 255));
            do_reset();
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 79) == 0) do_reset();
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
